// File: rtl/alu_mc_64_if.sv
// Operand/result handshake bundle for alu_mc_64: valid/ready operation channel,
// valid/ready result channel with NZCV flags, and the busy indicator.
interface alu_mc_64_if #(
    parameter int REGSIZE = 64
);
    logic               in_valid;
    logic               in_ready;
    logic [REGSIZE-1:0] A;
    logic [REGSIZE-1:0] B;
    logic [3:0]         ALU_Opcode;
    logic               out_valid;
    logic               out_ready;
    logic [REGSIZE-1:0] ALU_Out;
    logic               N;
    logic               Z;
    logic               C;
    logic               V;
    logic               busy;

    modport master (
        output in_valid, A, B, ALU_Opcode, out_ready,
        input  in_ready, out_valid, ALU_Out, N, Z, C, V, busy
    );

    modport slave (
        input  in_valid, A, B, ALU_Opcode, out_ready,
        output in_ready, out_valid, ALU_Out, N, Z, C, V, busy
    );
endinterface

// File: rtl/alu_mc_64.sv
// Multi-cycle ALU with registered result, ARM-style NZCV flags, barrel shifts and an
// iterative shift-add multiplier; define ALU_MC_DIV_EN to add the iterative unsigned divider.
module alu_mc_64 #(
    parameter int REGSIZE = 64,
    parameter int SHW     = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_mc_64_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t             state, state_next;
    logic [REGSIZE-1:0] a_r, b_r, acc_r;
    logic [SHW:0]       cnt_r;
    logic [REGSIZE-1:0] out_r;
    logic               n_r, z_r, c_r, v_r;
    logic               accept, is_iter_op;

    logic [REGSIZE-1:0] sc_res;
    logic               sc_c, sc_v;
    logic [SHW-1:0]     amt;
    logic [REGSIZE:0]   sum, lsl_w, lsr_w, asr_w;
    logic [REGSIZE-1:0] mul_acc_next, iter_res;

    assign accept = (state == IDLE) && bus.in_valid;
    assign amt    = bus.B[SHW-1:0];

`ifdef ALU_MC_DIV_EN
    logic               is_div_r;
    logic [REGSIZE:0]   div_trial;
    logic [REGSIZE-1:0] rem_next, quo_next;

    assign is_iter_op = (bus.ALU_Opcode == 4'd11) || (bus.ALU_Opcode == 4'd12);
    // Restoring step: bring in the next dividend bit, keep the subtraction only if it did not go negative
    assign div_trial  = {acc_r, a_r[REGSIZE-1]} - {1'b0, b_r};
    assign rem_next   = div_trial[REGSIZE] ? {acc_r[REGSIZE-2:0], a_r[REGSIZE-1]} : div_trial[REGSIZE-1:0];
    assign quo_next   = {a_r[REGSIZE-2:0], ~div_trial[REGSIZE]};
`else
    assign is_iter_op = (bus.ALU_Opcode == 4'd11);
`endif

    // Extra guard bit on each shift holds the last bit shifted out (zero when the amount is 0)
    assign lsl_w = {1'b0, bus.A} << amt;
    assign lsr_w = {bus.A, 1'b0} >> amt;
    assign asr_w = $signed({bus.A, 1'b0}) >>> amt;

    always_comb begin
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        sum    = '0;
        case (bus.ALU_Opcode)
            4'd0: sc_res = bus.A & bus.B;
            4'd1: sc_res = bus.A | bus.B;
            4'd2: sc_res = ~bus.A;
            4'd3: sc_res = bus.A;
            4'd4: sc_res = bus.B;
            4'd5: begin
                sum    = {1'b0, bus.A} + {1'b0, bus.B};
                sc_res = sum[REGSIZE-1:0];
                sc_c   = sum[REGSIZE];
                sc_v   = (bus.A[REGSIZE-1] == bus.B[REGSIZE-1]) && (sum[REGSIZE-1] != bus.A[REGSIZE-1]);
            end
            4'd6: begin
                sum    = {1'b0, bus.A} + {1'b0, ~bus.B} + (REGSIZE+1)'(1);
                sc_res = sum[REGSIZE-1:0];
                sc_c   = sum[REGSIZE];
                sc_v   = (bus.A[REGSIZE-1] != bus.B[REGSIZE-1]) && (sum[REGSIZE-1] != bus.A[REGSIZE-1]);
            end
            4'd7: sc_res = {bus.A[REGSIZE-1:16], bus.B[15:0]};
            4'd8: begin
                sc_res = lsl_w[REGSIZE-1:0];
                sc_c   = lsl_w[REGSIZE];
            end
            4'd9: begin
                sc_res = lsr_w[REGSIZE:1];
                sc_c   = lsr_w[0];
            end
            4'd10: begin
                sc_res = asr_w[REGSIZE:1];
                sc_c   = asr_w[0];
            end
            default: sc_res = '0;
        endcase
    end

    assign mul_acc_next = acc_r + (b_r[0] ? a_r : '0);

    always_comb begin
        iter_res = mul_acc_next;
`ifdef ALU_MC_DIV_EN
        if (is_div_r) begin
            iter_res = (b_r == '0) ? '0 : quo_next;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.in_valid) state_next = is_iter_op ? ITER : DONE;
            ITER: if (cnt_r == (SHW+1)'(1)) state_next = DONE;
            DONE: if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // MUL reuses a_r/b_r as shifting multiplicand/multiplier; UDIV uses a_r as dividend/quotient, acc_r as remainder
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            acc_r <= '0;
            cnt_r <= '0;
            out_r <= '0;
            n_r   <= 1'b0;
            z_r   <= 1'b0;
            c_r   <= 1'b0;
            v_r   <= 1'b0;
`ifdef ALU_MC_DIV_EN
            is_div_r <= 1'b0;
`endif
        end else if (accept) begin
            if (is_iter_op) begin
                a_r   <= bus.A;
                b_r   <= bus.B;
                acc_r <= '0;
                cnt_r <= (SHW+1)'(REGSIZE);
`ifdef ALU_MC_DIV_EN
                is_div_r <= (bus.ALU_Opcode == 4'd12);
`endif
            end else begin
                out_r <= sc_res;
                n_r   <= sc_res[REGSIZE-1];
                z_r   <= (sc_res == '0);
                c_r   <= sc_c;
                v_r   <= sc_v;
            end
        end else if (state == ITER) begin
            cnt_r <= cnt_r - (SHW+1)'(1);
`ifdef ALU_MC_DIV_EN
            if (is_div_r) begin
                a_r   <= quo_next;
                acc_r <= rem_next;
            end else begin
                acc_r <= mul_acc_next;
                a_r   <= a_r << 1;
                b_r   <= b_r >> 1;
            end
`else
            acc_r <= mul_acc_next;
            a_r   <= a_r << 1;
            b_r   <= b_r >> 1;
`endif
            if (cnt_r == (SHW+1)'(1)) begin
                out_r <= iter_res;
                n_r   <= iter_res[REGSIZE-1];
                z_r   <= (iter_res == '0);
                c_r   <= 1'b0;
                v_r   <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == ITER);
    assign bus.ALU_Out   = out_r;
    assign bus.N         = n_r;
    assign bus.Z         = z_r;
    assign bus.C         = c_r;
    assign bus.V         = v_r;
endmodule

// File: tb/tb_alu_mc_64.sv
// Bench for alu_mc_64: vector table driven through a scoreboard queue, plus
// hand-written sequences for result hold and reset during a multiply.
module tb_alu_mc_64;
    localparam int REGSIZE = 64;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic [3:0]  nzcv;
        int          lat;
        int          busy_cycles;
    } vec_t;

    typedef struct {
        string       name;
        logic [63:0] res;
        logic [3:0]  nzcv;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    vec_t vecs[$];
    exp_t sb[$];

    alu_mc_64_if #(.REGSIZE(REGSIZE)) bus ();

    alu_mc_64 #(.REGSIZE(REGSIZE), .SHW(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic addVec(input string name, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] res, input logic [3:0] nzcv,
                          input int lat, input int busy_cycles);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b;
        v.res = res; v.nzcv = nzcv; v.lat = lat; v.busy_cycles = busy_cycles;
        vecs.push_back(v);
    endtask

    // Presents one operation and waits (bounded) for its result; operands are scrambled after accept
    task automatic applyStimulus(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                 output int lat, output int busy_cycles);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.in_valid   = 1'b1;
        bus.ALU_Opcode = op;
        bus.A          = a;
        bus.B          = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.A        = {$urandom, $urandom};
        bus.B        = {$urandom, $urandom};
        lat          = 1;
        busy_cycles  = bus.busy ? 1 : 0;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (bus.busy) busy_cycles++;
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL scoreboard_empty: got result %h, expected no result", bus.ALU_Out);
            return;
        end
        e = sb.pop_front();
        check({e.name, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({e.name, "_res"}, bus.ALU_Out, e.res);
        check({e.name, "_nzcv"}, 64'({bus.N, bus.Z, bus.C, bus.V}), 64'(e.nzcv));
        check({e.name, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    endtask

    initial begin
        exp_t e;
        int   lat;
        int   busy_cycles;
        logic seen_valid;

        n_checks = 0;
        n_pass   = 0;

        addVec("sub_neg",   4'd6,  64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1, 0);
        addVec("sub_zero",  4'd6,  64'd7, 64'd7, 64'd0, 4'b0110, 1, 0);
        addVec("sub_pos",   4'd6,  64'd7, 64'd5, 64'd2, 4'b0010, 1, 0);
        addVec("add_ovf",   4'd5,  64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b1001, 1, 0);
        addVec("add_carry", 4'd5,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b0110, 1, 0);
        addVec("and",       4'd0,  64'hF0F0, 64'hFF00, 64'hF000, 4'b0000, 1, 0);
        addVec("orr_zero",  4'd1,  64'd0, 64'd0, 64'd0, 4'b0100, 1, 0);
        addVec("not",       4'd2,  64'd0, 64'd9, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1, 0);
        addVec("mov_a",     4'd3,  64'h8000_0000_0000_0000, 64'd3, 64'h8000_0000_0000_0000, 4'b1000, 1, 0);
        addVec("mov_b",     4'd4,  64'd1, 64'h55, 64'h55, 4'b0000, 1, 0);
        addVec("movk",      4'd7,  64'h1111_2222_3333_4444, 64'h9999_ABCD, 64'h1111_2222_3333_ABCD, 4'b0000, 1, 0);
        addVec("lsl",       4'd8,  64'h8000_0000_0000_0001, 64'h41, 64'd2, 4'b0010, 1, 0);
        addVec("lsr",       4'd9,  64'd3, 64'd1, 64'd1, 4'b0010, 1, 0);
        addVec("lsr_amt0",  4'd9,  64'd5, 64'h40, 64'd5, 4'b0000, 1, 0);
        addVec("asr_63",    4'd10, 64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1, 0);
        addVec("asr_4",     4'd10, 64'h8000_0000_0000_0018, 64'd4, 64'hF800_0000_0000_0001, 4'b1010, 1, 0);
        addVec("reserved",  4'd13, 64'd7, 64'd7, 64'd0, 4'b0100, 1, 0);
        addVec("mul",       4'd11, 64'h12345, 64'h1000, 64'h1234_5000, 4'b0000, 65, 64);
        addVec("mul_neg",   4'd11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 4'b1000, 65, 64);
`ifdef ALU_MC_DIV_EN
        addVec("udiv",      4'd12, 64'd100, 64'd7, 64'd14, 4'b0000, 65, 64);
        addVec("udiv_by0",  4'd12, 64'd100, 64'd0, 64'd0, 4'b0100, 65, 64);
`else
        addVec("udiv_off",  4'd12, 64'd100, 64'd7, 64'd0, 4'b0100, 1, 0);
`endif

        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b1;
        bus.A          = '0;
        bus.B          = '0;
        bus.ALU_Opcode = '0;
        #1;
        check("reset_out",       bus.ALU_Out, 64'd0);
        check("reset_nzcv",      64'({bus.N, bus.Z, bus.C, bus.V}), 64'd0);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_busy",      64'(bus.busy), 64'd0);
        check("reset_in_ready",  64'(bus.in_ready), 64'd1);
        #12 rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            e.name = vecs[i].name; e.res = vecs[i].res; e.nzcv = vecs[i].nzcv;
            sb.push_back(e);
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat, busy_cycles);
            check({vecs[i].name, "_latency"}, 64'(lat), 64'(vecs[i].lat));
            check({vecs[i].name, "_busy_cycles"}, 64'(busy_cycles), 64'(vecs[i].busy_cycles));
            checkOutput();
            @(posedge clk); #1;
        end

        // Result must hold unchanged while the consumer stalls
        bus.out_ready = 1'b0;
        e.name = "add_hold"; e.res = 64'h8000_0000_0000_0000; e.nzcv = 4'b1001;
        sb.push_back(e);
        applyStimulus(4'd5, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, lat, busy_cycles);
        checkOutput();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("hold_res",       bus.ALU_Out, 64'h8000_0000_0000_0000);
            check("hold_nzcv",      64'({bus.N, bus.Z, bus.C, bus.V}), 64'b1001);
            check("hold_out_valid", 64'(bus.out_valid), 64'd1);
            check("hold_in_ready",  64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_out_valid", 64'(bus.out_valid), 64'd0);
        check("release_in_ready",  64'(bus.in_ready), 64'd1);

        // Asynchronous reset in the middle of a multiply discards it
        bus.in_valid   = 1'b1;
        bus.ALU_Opcode = 4'd11;
        bus.A          = 64'h12345;
        bus.B          = 64'h1000;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("mid_mul_busy", 64'(bus.busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mul_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_mul_busy",      64'(bus.busy), 64'd0);
        check("rst_mul_in_ready",  64'(bus.in_ready), 64'd1);
        check("rst_mul_out",       bus.ALU_Out, 64'd0);
        check("rst_mul_nzcv",      64'({bus.N, bus.Z, bus.C, bus.V}), 64'd0);
        #2 rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid || bus.busy) seen_valid = 1'b1;
        end
        check("rst_mul_no_result", 64'(seen_valid), 64'd0);

        e.name = "post_reset_movb"; e.res = 64'hABCD; e.nzcv = 4'b0000;
        sb.push_back(e);
        applyStimulus(4'd4, 64'd0, 64'hABCD, lat, busy_cycles);
        check("post_reset_latency", 64'(lat), 64'd1);
        checkOutput();
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
